// File: rtl/ai_job_arbiter.sv
// Two-requester round-robin front end for the single ai accelerator: snapshots the
// granted board, drives it over Avalon-MM, reads the result back and acks the owner.
module ai_job_arbiter #(
    parameter int NUM_WORDS   = 9,
    parameter int RESULT_ADDR = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req0,
    input  logic                      req1,
    input  logic [32*NUM_WORDS-1:0]   job0,
    input  logic [32*NUM_WORDS-1:0]   job1,
    output logic                      ack0,
    output logic                      ack1,
    output logic [31:0]               result,
    output logic                      busy,
    output logic [3:0]                ai_addr,
    output logic                      ai_write,
    output logic                      ai_read,
    output logic [31:0]               ai_wdata,
    input  logic                      ai_waitreq,
    input  logic [31:0]               ai_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        START,
        READ,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [3:0]                k;
    logic [3:0]                k_next;
    logic                      owner;
    logic                      owner_next;
    logic                      last_grant;
    logic                      grant;
    logic [32*NUM_WORDS-1:0]   snapshot;
    logic [32*NUM_WORDS-1:0]   snap_src;
    logic [31:0]               words [NUM_WORDS];

    logic                      write_next;
    logic                      read_next;
    logic [3:0]                addr_next;
    logic [31:0]               wdata_next;

    // Next-state: arbitration in IDLE, then one bus transfer per non-stalled edge.
    always_comb begin
        state_next = state;
        k_next     = k;
        owner_next = owner;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_grant)) begin
                    grant      = 1'b1;
                    owner_next = 1'b0;
                    k_next     = 4'd1;
                    state_next = WRITE;
                end else if (req1) begin
                    grant      = 1'b1;
                    owner_next = 1'b1;
                    k_next     = 4'd1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!ai_waitreq) begin
                    if (k == 4'(NUM_WORDS)) begin
                        state_next = START;
                    end else begin
                        k_next = k + 4'd1;
                    end
                end
            end
            START: begin
                if (!ai_waitreq) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (!ai_waitreq) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // On the grant edge the snapshot is not loaded yet, so the first word comes
    // straight from the granted job input.
    always_comb begin
        snap_src = grant ? (owner_next ? job1 : job0) : snapshot;
        for (int i = 0; i < NUM_WORDS; i++) begin
            words[i] = snap_src[32*i +: 32];
        end
    end

    // Bus outputs are registered from the next state, so they stay frozen while stalled.
    always_comb begin
        write_next = 1'b0;
        read_next  = 1'b0;
        addr_next  = 4'd0;
        wdata_next = 32'd0;
        case (state_next)
            WRITE: begin
                write_next = 1'b1;
                addr_next  = k_next;
                wdata_next = words[k_next - 4'd1];
            end
            START: begin
                write_next = 1'b1;
                wdata_next = 32'd1;
            end
            READ: begin
                read_next = 1'b1;
                addr_next = 4'(RESULT_ADDR);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            k          <= 4'd1;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            result     <= 32'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            ai_write   <= 1'b0;
            ai_read    <= 1'b0;
            ai_addr    <= 4'd0;
            ai_wdata   <= 32'd0;
        end else begin
            state    <= state_next;
            k        <= k_next;
            owner    <= owner_next;
            if (grant) begin
                last_grant <= owner_next;
            end
            if (state == READ && !ai_waitreq) begin
                result <= ai_rdata;
            end
            ack0     <= (state_next == DONE) && !owner_next;
            ack1     <= (state_next == DONE) && owner_next;
            busy     <= (state_next != IDLE);
            ai_write <= write_next;
            ai_read  <= read_next;
            ai_addr  <= addr_next;
            ai_wdata <= wdata_next;
        end
    end

    // Board data carries no reset; it is only meaningful after a grant.
    always_ff @(posedge clock) begin
        if (grant) begin
            snapshot <= snap_src;
        end
    end

endmodule

// File: tb/tb_ai_job_arbiter.sv
// Directed bench for ai_job_arbiter with a small stalling Avalon slave model and
// a transfer log checked against hand-computed job contents and latencies.
module tb_ai_job_arbiter;

    localparam int NW = 9;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [32*NW-1:0]  job0 = '0;
    logic [32*NW-1:0]  job1 = '0;
    logic              ack0;
    logic              ack1;
    logic [31:0]       result;
    logic              busy;
    logic [3:0]        ai_addr;
    logic              ai_write;
    logic              ai_read;
    logic [31:0]       ai_wdata;
    logic              ai_waitreq;
    logic [31:0]       ai_rdata;

    always #5 clock = ~clock;

    ai_job_arbiter #(.NUM_WORDS(NW), .RESULT_ADDR(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .job0       (job0),
        .job1       (job1),
        .ack0       (ack0),
        .ack1       (ack1),
        .result     (result),
        .busy       (busy),
        .ai_addr    (ai_addr),
        .ai_write   (ai_write),
        .ai_read    (ai_read),
        .ai_wdata   (ai_wdata),
        .ai_waitreq (ai_waitreq),
        .ai_rdata   (ai_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Transfer log and slave state, updated on the active edge.
    int          cyc = 0;
    int          log_n = 0;
    logic [3:0]  log_addr [256];
    logic [31:0] log_data [256];
    logic        log_wr   [256];
    int          ack0_cnt = 0;
    int          ack1_cnt = 0;
    int          both_err = 0;
    logic [31:0] slave_w1 = 32'd0;
    logic [31:0] rd_base = 32'd0;

    assign ai_rdata = rd_base + slave_w1;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ack0) ack0_cnt <= ack0_cnt + 1;
        if (ack1) ack1_cnt <= ack1_cnt + 1;
        if (ai_write && ai_read) both_err <= both_err + 1;
        if ((ai_write || ai_read) && !ai_waitreq && log_n < 256) begin
            log_addr[log_n] <= ai_addr;
            log_data[log_n] <= ai_write ? ai_wdata : ai_rdata;
            log_wr[log_n]   <= ai_write;
            log_n           <= log_n + 1;
            if (ai_write && ai_addr == 4'd1) slave_w1 <= ai_wdata;
        end
    end

    // Slave wait generator plus a hold checker for stalled transfers.
    int          stall_seq = 0;
    int          seen_seq = 0;
    int          stall_n = 0;
    int          stall_left = 0;
    logic        stall_rd = 1'b0;
    logic [3:0]  stall_addr = 4'd0;
    logic        wreq = 1'b0;
    logic        prev_wait = 1'b0;
    logic [37:0] saved = '0;
    int          hold_err = 0;

    assign ai_waitreq = wreq;

    always @(negedge clock) begin
        logic nw;
        logic match;
        nw    = 1'b0;
        match = stall_rd ? ai_read : (ai_write && ai_addr == stall_addr);
        if (prev_wait && {ai_write, ai_read, ai_addr, ai_wdata} !== saved)
            hold_err <= hold_err + 1;
        if (stall_seq != seen_seq) begin
            seen_seq   <= stall_seq;
            stall_left <= stall_n;
        end else if (stall_left > 0 && match) begin
            nw = 1'b1;
            stall_left <= stall_left - 1;
        end
        wreq      <= nw;
        prev_wait <= nw;
        saved     <= {ai_write, ai_read, ai_addr, ai_wdata};
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*NW-1:0] pack(input logic [31:0] w[NW]);
        logic [32*NW-1:0] p;
        for (int i = 0; i < NW; i++) p[32*i +: 32] = w[i];
        return p;
    endfunction

    task automatic wait_ack(input string tag, output int at, output logic who,
                            output logic [31:0] res);
        at  = -1;
        who = 1'b0;
        res = 32'd0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ack0 || ack1) begin
                at  = cyc;
                who = ack1;
                res = result;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 64'(at >= 0), 64'd1);
    endtask

    task automatic check_xfers(input string tag, input int base, input logic [31:0] w[NW],
                               input logic [31:0] rres);
        chk({tag, "_xfer_count"}, 64'(log_n - base), 64'd11);
        for (int k = 1; k <= NW; k++) begin
            chk($sformatf("%s_write%0d", tag, k),
                64'({log_wr[base+k-1], log_addr[base+k-1], log_data[base+k-1]}),
                64'({1'b1, 4'(k), w[k-1]}));
        end
        chk({tag, "_start"}, 64'({log_wr[base+NW], log_addr[base+NW], log_data[base+NW]}),
            64'({1'b1, 4'd0, 32'd1}));
        chk({tag, "_read"}, 64'({log_wr[base+NW+1], log_addr[base+NW+1], log_data[base+NW+1]}),
            64'({1'b0, 4'd1, rres}));
    endtask

    initial begin
        logic [31:0] w [NW];
        logic [31:0] dead [NW];
        int          t0;
        int          at;
        int          base;
        int          prev_at;
        int          a0;
        int          a1;
        logic        who;
        logic [31:0] res;
        logic        found;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", 64'({ack0, ack1, busy, ai_write, ai_read, ai_addr, ai_wdata}), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_not_busy", 64'({busy, ai_write, ai_read}), 64'd0);

        // Single zero-wait job from requester 0
        w = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'h1f};
        rd_base = 32'h1234;
        job0 = pack(w);
        base = log_n;
        req0 = 1'b1;
        t0 = cyc;
        tick();
        chk("t1_first_write", 64'({busy, ai_write, ai_read, ai_addr, ai_wdata}),
            64'({1'b1, 1'b1, 1'b0, 4'd1, 32'd0}));
        wait_ack("t1", at, who, res);
        req0 = 1'b0;
        chk("t1_latency", 64'(at - t0), 64'd12);
        chk("t1_owner", 64'(who), 64'd0);
        chk("t1_result", 64'(res), 64'h1234);
        tick();
        chk("t1_after_done", 64'({ack0, ack1, busy}), 64'd0);
        check_xfers("t1", base, w, 32'h1234);
        chk("t1_no_ack1", 64'(ack1_cnt), 64'd0);

        // Compute stall of 20 cycles on the read
        for (int i = 0; i < NW; i++) w[i] = 32'(i * 3);
        rd_base = 32'd37;
        stall_rd = 1'b1;
        stall_n = 20;
        stall_seq++;
        tick();
        job0 = pack(w);
        base = log_n;
        req0 = 1'b1;
        t0 = cyc;
        repeat (16) tick();
        chk("t2_stall_mid", 64'({ai_read, ai_write, ai_addr, ai_waitreq}),
            64'({1'b1, 1'b0, 4'd1, 1'b1}));
        wait_ack("t2", at, who, res);
        req0 = 1'b0;
        chk("t2_latency", 64'(at - t0), 64'd32);
        chk("t2_result", 64'({who, res}), 64'({1'b0, 32'd37}));
        chk("t2_hold_stable", 64'(hold_err), 64'd0);
        tick();
        check_xfers("t2", base, w, 32'd37);

        // Tie from reset, both held: grant order 0,1,0,1
        reset_n = 1'b0;
        for (int i = 0; i < NW; i++) w[i] = 32'd0;
        w[0] = 32'h100;
        job0 = pack(w);
        w[0] = 32'h200;
        job1 = pack(w);
        rd_base = 32'd5;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        t0 = cyc;
        prev_at = t0 - 1;
        for (int j = 0; j < 4; j++) begin
            wait_ack($sformatf("t3_job%0d", j), at, who, res);
            chk($sformatf("t3_owner%0d", j), 64'(who), 64'(j % 2));
            chk($sformatf("t3_result%0d", j), 64'(res), (j % 2 == 0) ? 64'h105 : 64'h205);
            chk($sformatf("t3_spacing%0d", j), 64'(at - prev_at), (j == 0) ? 64'd13 : 64'd13);
            prev_at = at;
            if (j == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        tick();
        chk("t3_idle_after", 64'({busy, ai_write, ai_read}), 64'd0);

        // Snapshot plus write backpressure on addr 5, requester 1
        for (int i = 0; i < NW; i++) w[i] = 32'h11 + 32'(i);
        for (int i = 0; i < NW; i++) dead[i] = 32'hDEADBEEF;
        rd_base = 32'd0;
        stall_rd = 1'b0;
        stall_addr = 4'd5;
        stall_n = 3;
        stall_seq++;
        tick();
        job1 = pack(w);
        base = log_n;
        req1 = 1'b1;
        t0 = cyc;
        tick();
        tick();
        job1 = pack(dead);
        repeat (5) tick();
        chk("t4_wr_stall_mid", 64'({ai_write, ai_addr, ai_wdata, ai_waitreq}),
            64'({1'b1, 4'd5, 32'h15, 1'b1}));
        wait_ack("t4", at, who, res);
        req1 = 1'b0;
        chk("t4_latency", 64'(at - t0), 64'd15);
        chk("t4_result", 64'({who, res}), 64'({1'b1, 32'h11}));
        chk("t4_hold_stable", 64'(hold_err), 64'd0);
        tick();
        check_xfers("t4", base, w, 32'h11);

        // Asynchronous reset during WRITE k=4
        for (int i = 0; i < NW; i++) w[i] = 32'h40 + 32'(i);
        job0 = pack(w);
        a0 = ack0_cnt;
        a1 = ack1_cnt;
        req0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ai_write && ai_addr == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reached_k4", 64'(found), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_async_clear", 64'({ack0, ack1, busy, ai_write, ai_read, ai_addr, ai_wdata}), 64'd0);
        req0 = 1'b0;
        repeat (3) tick();
        chk("t5_no_ack", 64'((ack0_cnt - a0) + (ack1_cnt - a1)), 64'd0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < NW; i++) w[i] = 32'h70 + 32'(i);
        job1 = pack(w);
        rd_base = 32'd1;
        base = log_n;
        req1 = 1'b1;
        t0 = cyc;
        wait_ack("t5", at, who, res);
        req1 = 1'b0;
        chk("t5_latency", 64'(at - t0), 64'd12);
        chk("t5_result", 64'({who, res}), 64'({1'b1, 32'h71}));
        tick();
        check_xfers("t5", base, w, 32'h71);

        chk("never_write_and_read", 64'(both_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ai_job_arbiter.md
# ai_job_arbiter

Shares the single `ai` targeting accelerator between two requesters, for example two computer-controlled players or a player hint plus the CPU opponent. It round-robin arbitrates pending jobs and snapshots the granted requester's board state. It then acts as Avalon-MM master to the `ai` slave: it writes the nine board words, issues the start write, waits out the compute stall, and reads back the result. Each result is returned to its requester with a one-cycle `ack` pulse.

## Interface
Parameters:
- NUM_WORDS, 9, board-state words written per job, to slave addresses 1..NUM_WORDS
- RESULT_ADDR, 1, slave address read to obtain the job result

Ports:
- clock  in  1  single system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  job request from requester 0 / 1; held high until own ack
- job0 / job1  in  32*NUM_WORDS  board state; word k-1 is bits [32k-1:32(k-1)]; sampled only at grant
- ack0 / ack1  out  1  one-cycle pulse: granted job complete, `result` valid
- result  out  32  last job result; held until next ack
- busy  out  1  high from grant through DONE
- ai_addr  out  4  slave address
- ai_write  out  1  slave write request
- ai_read  out  1  slave read request
- ai_wdata  out  32  slave write data
- ai_waitreq  in  1  slave wait_request; transfer completes on an edge where it is low
- ai_rdata  in  32  slave read data

## Operation
- States: IDLE, WRITE, START, READ, DONE.
- IDLE:
  - With no req, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not granted last. `last_grant` resets to 1, so requester 0 wins the first tie.
  - On grant: latch that requester's `job` into a 288-bit snapshot, record `owner`, set `last_grant`=owner, set k=1, go to WRITE.
- WRITE: drive ai_write=1, ai_addr=k, ai_wdata=snapshot word k-1.
  - On an edge with ai_waitreq=0: if k=NUM_WORDS go to START, else k++.
- START: drive ai_write=1, ai_addr=0, ai_wdata=32'd1.
  - On completion go to READ.
- READ: drive ai_read=1, ai_addr=RESULT_ADDR.
  - The slave stalls with ai_waitreq high while computing.
  - On an edge with ai_waitreq=0, capture ai_rdata into `result` and go to DONE.
- DONE: ack[owner]=1 for exactly this cycle, then go to IDLE.
- All master outputs are registered and held constant while ai_waitreq=1. ai_write and ai_read are never high together.
- Outside WRITE/START/READ: ai_write=0, ai_read=0, ai_addr=0, ai_wdata=0.
- req dropped mid-job: the job still completes and ack still pulses; abort is not supported.
- The non-granted requester's req is ignored until IDLE, so it is never lost.
- The requester must drop req by the first IDLE cycle after its ack. A req seen high in IDLE is a new job.
- A job input that changes after grant has no effect on the current job.

## Timing
- Reset (async, immediate): state=IDLE, k=1, last_grant=1, result=0.
- All outputs reset to 0: ack0, ack1, busy, ai_write, ai_read, ai_addr, ai_wdata.
- A reset mid-transfer abandons the job with no ack. The slave shares reset_n.
- Grant latency: req high in IDLE at edge T puts the state in WRITE at cycle T+1; busy=1 from T+1.
- Zero-wait job length: NUM_WORDS writes + 1 start + 1 read = 11 cycles in the master states, then 1 DONE cycle. req to ack is 12 cycles.
- Each slave wait cycle adds exactly one cycle.
- busy falls in the first IDLE cycle after DONE.
- Back-to-back: the earliest next grant is the IDLE cycle after DONE, so there is at least one idle bus cycle between jobs.
- result changes only at the edge entering DONE.

## Test plan
- Single job, zero wait:
  - Stimulus: req0=1, job0 words 0..8 = 0,0,0,0,1,0,0,0,0x1f.
  - Required: writes at addr 1..9 with those values, then addr 0 data 1, then a read at addr 1.
  - Required: ack0 exactly 12 cycles after req0; ack1 never pulses.
- Compute stall:
  - Stimulus: slave holds ai_waitreq high 20 cycles on the READ; ai_rdata=37.
  - Required: ai_read and ai_addr stay stable throughout; result=37 at ack; total job length 32 cycles.
- Tie and round-robin:
  - Stimulus: req0 and req1 both high from reset and held.
  - Required: grant order 0,1,0,1; each ack reaches the correct requester with that requester's own result.
- Snapshot:
  - Stimulus: change job1 two cycles after grant.
  - Required: written words match the pre-grant value.
- Write backpressure:
  - Stimulus: ai_waitreq high for 3 cycles on the write to addr 5.
  - Required: addr and data held; k does not advance; no duplicate write.
- Reset mid-job:
  - Stimulus: assert reset_n=0 during WRITE k=4, asynchronously mid-cycle.
  - Required: all outputs 0 immediately, no ack; after release, a req1 job runs from addr 1.
